// File: rtl/leg_alu_issue_stage_if.sv
// leg_alu_issue_stage_if: issue-stage bus covering the instruction input, register file, writeback and ALU sides
interface leg_alu_issue_stage_if #(parameter int ADDR_W = 3);
  logic              in_valid, in_ready;
  logic [7:0]        in_opcode, in_arg1, in_arg2, in_dest;
  logic [ADDR_W-1:0] rf_raddr1, rf_raddr2;
  logic [7:0]        rf_rdata1, rf_rdata2;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [7:0]        wb_data;
  logic              alu_valid, alu_ready;
  logic [7:0]        alu_opcode, alu_in1, alu_in2, alu_dest;
  modport master (
    output in_valid, in_opcode, in_arg1, in_arg2, in_dest, rf_rdata1, rf_rdata2,
           wb_valid, wb_addr, wb_data, alu_ready,
    input  in_ready, rf_raddr1, rf_raddr2, alu_valid, alu_opcode, alu_in1, alu_in2, alu_dest
  );
  modport slave (
    input  in_valid, in_opcode, in_arg1, in_arg2, in_dest, rf_rdata1, rf_rdata2,
           wb_valid, wb_addr, wb_data, alu_ready,
    output in_ready, rf_raddr1, rf_raddr2, alu_valid, alu_opcode, alu_in1, alu_in2, alu_dest
  );
endinterface

// File: rtl/leg_alu_issue_stage.sv
// leg_alu_issue_stage: resolves operands with writeback forwarding and issues them to the ALU through a snooping 2-entry skid buffer
module leg_alu_issue_stage #(
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  leg_alu_issue_stage_if.slave bus,
  output logic [CNT_W-1:0]     stall_cnt
);
  typedef struct packed {
    logic [7:0]        op, in1, in2, dest;
    logic [ADDR_W-1:0] s1, s2;
    logic              r1, r2;
  } ent_t;
  ent_t main_q, skid_q, main_s, skid_s, new_e;
  logic main_v, skid_v, accept, xfer, to_skid;
  function automatic ent_t snoop(ent_t e, logic wv, logic [ADDR_W-1:0] wa, logic [7:0] wd);
    ent_t r;
    r = e;
    r.in1 = (wv && e.r1 && e.s1 == wa) ? wd : e.in1;
    r.in2 = (wv && e.r2 && e.s2 == wa) ? wd : e.in2;
    return r;
  endfunction
  assign bus.rf_raddr1  = bus.in_arg1[ADDR_W-1:0];
  assign bus.rf_raddr2  = bus.in_arg2[ADDR_W-1:0];
  assign bus.in_ready   = !skid_v && !rst;
  assign bus.alu_valid  = main_v;
  assign bus.alu_opcode = main_q.op;
  assign bus.alu_in1    = main_q.in1;
  assign bus.alu_in2    = main_q.in2;
  assign bus.alu_dest   = main_q.dest;
  assign accept  = bus.in_valid && bus.in_ready;
  assign xfer    = main_v && bus.alu_ready;
  assign to_skid = accept && main_v && !xfer;
  // Resolve the incoming operands (immediate, forwarded writeback, or register file) and snoop held entries
  always_comb begin
    new_e.op   = bus.in_opcode;
    new_e.dest = bus.in_dest;
    new_e.s1   = bus.in_arg1[ADDR_W-1:0];
    new_e.s2   = bus.in_arg2[ADDR_W-1:0];
    new_e.r1   = !bus.in_opcode[7];
    new_e.r2   = !bus.in_opcode[6];
    new_e.in1  = bus.in_opcode[7] ? bus.in_arg1 :
                 (bus.wb_valid && bus.wb_addr == new_e.s1) ? bus.wb_data : bus.rf_rdata1;
    new_e.in2  = bus.in_opcode[6] ? bus.in_arg2 :
                 (bus.wb_valid && bus.wb_addr == new_e.s2) ? bus.wb_data : bus.rf_rdata2;
    main_s     = main_v ? snoop(main_q, bus.wb_valid, bus.wb_addr, bus.wb_data) : main_q;
    skid_s     = skid_v ? snoop(skid_q, bus.wb_valid, bus.wb_addr, bus.wb_data) : skid_q;
  end
  // FIFO-ordered main/skid update; main refills from skid first, then from the input
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      main_v <= (!main_v || xfer) ? (skid_v || accept) : 1'b1;
      main_q <= (!main_v || xfer) ? (skid_v ? skid_s : accept ? new_e : main_s) : main_s;
      skid_v <= skid_v ? !xfer : to_skid;
      skid_q <= skid_v ? skid_s : to_skid ? new_e : skid_q;
    end
  end
  // Count cycles where an instruction is offered but refused, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (bus.in_valid && !bus.in_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_leg_alu_issue_stage.sv
// tb_leg_alu_issue_stage: scenario tasks plus an issue-order scoreboard for leg_alu_issue_stage
module tb_leg_alu_issue_stage;
  typedef struct {
    logic [7:0] op, in1, in2, dest;
    logic [2:0] s1, s2;
    logic       r1, r2;
  } exp_t;
  logic        clk, rst, flush;
  logic [15:0] stall_cnt;
  logic [7:0]  rf [8];
  exp_t        q [$];
  int          vec, err;
  leg_alu_issue_stage_if #(.ADDR_W(3)) bus ();
  leg_alu_issue_stage #(.ADDR_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .stall_cnt(stall_cnt)
  );
  assign bus.rf_rdata1 = rf[bus.rf_raddr1];
  assign bus.rf_rdata2 = rf[bus.rf_raddr2];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (rst) q.delete();
    else begin
      if (bus.alu_valid && bus.alu_ready) begin
        vec++;
        if (q.size() == 0) begin
          err++;
          $display("FAIL sb_unexpected: got op=%h in1=%h in2=%h dest=%h, want no issue",
                   bus.alu_opcode, bus.alu_in1, bus.alu_in2, bus.alu_dest);
        end else begin
          e = q.pop_front();
          if ({bus.alu_opcode, bus.alu_in1, bus.alu_in2, bus.alu_dest} !== {e.op, e.in1, e.in2, e.dest}) begin
            err++;
            $display("FAIL sb_issue: got op=%h in1=%h in2=%h dest=%h, want op=%h in1=%h in2=%h dest=%h",
                     bus.alu_opcode, bus.alu_in1, bus.alu_in2, bus.alu_dest, e.op, e.in1, e.in2, e.dest);
          end
        end
      end
      if (bus.wb_valid) foreach (q[i]) begin
        if (q[i].r1 && q[i].s1 == bus.wb_addr) q[i].in1 = bus.wb_data;
        if (q[i].r2 && q[i].s2 == bus.wb_addr) q[i].in2 = bus.wb_data;
      end
      if (flush) q.delete();
      else if (bus.in_valid && bus.in_ready) begin
        e.op   = bus.in_opcode;
        e.dest = bus.in_dest;
        e.r1   = !bus.in_opcode[7];
        e.r2   = !bus.in_opcode[6];
        e.s1   = bus.in_arg1[2:0];
        e.s2   = bus.in_arg2[2:0];
        e.in1  = !e.r1 ? bus.in_arg1 : (bus.wb_valid && bus.wb_addr == e.s1) ? bus.wb_data : rf[e.s1];
        e.in2  = !e.r2 ? bus.in_arg2 : (bus.wb_valid && bus.wb_addr == e.s2) ? bus.wb_data : rf[e.s2];
        q.push_back(e);
      end
      if (bus.wb_valid) rf[bus.wb_addr] = bus.wb_data;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [7:0] op, a1, a2, d);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_arg1   = a1;
    bus.in_arg2   = a2;
    bus.in_dest   = d;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    vec++;
    if ({bus.alu_valid, bus.alu_in1, stall_cnt, bus.in_ready} !== 26'd0) begin
      err++;
      $display("FAIL reset_state: got valid=%b in1=%h stall=%0d ready=%b, want all 0",
               bus.alu_valid, bus.alu_in1, stall_cnt, bus.in_ready);
    end
    rst = 1'b0;
    #1;
    vec++;
    if (bus.in_ready !== 1'b1) begin err++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
  endtask
  task automatic test_immediates();
    bus.alu_ready = 1'b1;
    drive(8'hC0, 8'd5, 8'd7, 8'd3);
    cyc();
    bus.in_valid = 1'b0;
    vec++;
    if ({bus.alu_valid, bus.alu_in1, bus.alu_in2} !== {1'b1, 8'd5, 8'd7}) begin
      err++;
      $display("FAIL imm_issue: got valid=%b in1=%h in2=%h, want 1 05 07", bus.alu_valid, bus.alu_in1, bus.alu_in2);
    end
    cyc();
    vec++;
    if (bus.alu_valid !== 1'b0) begin err++; $display("FAIL imm_drain: got valid=%b want 0", bus.alu_valid); end
  endtask
  task automatic test_forward();
    rf[2] = 8'h10;
    rf[3] = 8'h21;
    drive(8'h01, 8'd2, 8'd3, 8'd4);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 3'd2;
    bus.wb_data  = 8'h33;
    cyc();
    bus.in_valid = 1'b0;
    bus.wb_valid = 1'b0;
    vec++;
    if ({bus.alu_in1, bus.alu_in2} !== 16'h3321) begin
      err++;
      $display("FAIL fwd_operands: got in1=%h in2=%h, want 33 21", bus.alu_in1, bus.alu_in2);
    end
    cyc();
  endtask
  task automatic test_skid();
    logic [15:0] s0;
    bus.alu_ready = 1'b0;
    drive(8'hC2, 8'h11, 8'h12, 8'h01);
    cyc();
    drive(8'hC3, 8'h21, 8'h22, 8'h02);
    cyc();
    vec++;
    if (bus.in_ready !== 1'b0) begin err++; $display("FAIL skid_full_ready: got %b want 0", bus.in_ready); end
    drive(8'hC4, 8'h31, 8'h32, 8'h03);
    s0 = stall_cnt;
    cyc();
    cyc();
    vec++;
    if ({stall_cnt, bus.alu_opcode} !== {s0 + 16'd2, 8'hC2}) begin
      err++;
      $display("FAIL skid_stall: got stall=%0d op=%h, want stall=%0d op=c2", stall_cnt, bus.alu_opcode, s0 + 16'd2);
    end
    bus.alu_ready = 1'b1;
    cyc();
    vec++;
    if ({bus.in_ready, bus.alu_opcode} !== {1'b1, 8'hC3}) begin
      err++;
      $display("FAIL skid_drain_b: got ready=%b op=%h, want 1 c3", bus.in_ready, bus.alu_opcode);
    end
    cyc();
    bus.in_valid = 1'b0;
    vec++;
    if ({bus.alu_valid, bus.alu_opcode} !== {1'b1, 8'hC4}) begin
      err++;
      $display("FAIL skid_drain_c: got valid=%b op=%h, want 1 c4", bus.alu_valid, bus.alu_opcode);
    end
    cyc();
  endtask
  task automatic test_snoop();
    bus.alu_ready = 1'b0;
    rf[4] = 8'h11;
    drive(8'h41, 8'd4, 8'h5A, 8'h09);
    cyc();
    drive(8'h82, 8'h77, 8'd4, 8'h0A);
    cyc();
    bus.in_valid = 1'b0;
    vec++;
    if (bus.alu_in1 !== 8'h11) begin err++; $display("FAIL snoop_before: got in1=%h want 11", bus.alu_in1); end
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 3'd4;
    bus.wb_data  = 8'hAA;
    cyc();
    bus.wb_valid = 1'b0;
    vec++;
    if ({bus.alu_in1, bus.alu_in2} !== 16'hAA5A) begin
      err++;
      $display("FAIL snoop_main: got in1=%h in2=%h, want aa 5a", bus.alu_in1, bus.alu_in2);
    end
    bus.alu_ready = 1'b1;
    cyc();
    vec++;
    if ({bus.alu_in1, bus.alu_in2} !== 16'h77AA) begin
      err++;
      $display("FAIL snoop_skid: got in1=%h in2=%h, want 77 aa", bus.alu_in1, bus.alu_in2);
    end
    cyc();
  endtask
  task automatic test_flush();
    bus.alu_ready = 1'b0;
    drive(8'hC5, 8'h01, 8'h02, 8'h03);
    cyc();
    drive(8'hC6, 8'h04, 8'h05, 8'h06);
    cyc();
    drive(8'hC7, 8'h07, 8'h08, 8'h09);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    vec++;
    if ({bus.alu_valid, bus.in_ready} !== 2'b01) begin
      err++;
      $display("FAIL flush_full: got valid=%b ready=%b, want 0 1", bus.alu_valid, bus.in_ready);
    end
    drive(8'hC8, 8'h0A, 8'h0B, 8'h0C);
    cyc();
    drive(8'hC9, 8'h0D, 8'h0E, 8'h0F);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    vec++;
    if (bus.alu_valid !== 1'b0) begin err++; $display("FAIL flush_accept: got valid=%b want 0", bus.alu_valid); end
    bus.alu_ready = 1'b1;
    repeat (3) cyc();
    vec++;
    if (bus.alu_valid !== 1'b0) begin err++; $display("FAIL flush_later: got valid=%b want 0", bus.alu_valid); end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 80; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_opcode = 8'($urandom);
      bus.in_arg1   = 8'($urandom);
      bus.in_arg2   = 8'($urandom);
      bus.in_dest   = 8'($urandom);
      bus.wb_valid  = ($urandom_range(0, 2) == 0);
      bus.wb_addr   = 3'($urandom);
      bus.wb_data   = 8'($urandom);
      bus.alu_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    bus.in_valid  = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.alu_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() != 0; k++) cyc();
    vec++;
    if (q.size() != 0) begin err++; $display("FAIL b2b_drain: got %0d pending, want 0", q.size()); end
  endtask
  task automatic test_midreset();
    bus.alu_ready = 1'b0;
    drive(8'hD1, 8'h01, 8'h02, 8'h03);
    cyc();
    drive(8'hD2, 8'h04, 8'h05, 8'h06);
    cyc();
    cyc();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    vec++;
    if ({bus.alu_valid, bus.in_ready, stall_cnt} !== {2'b01, 16'd0}) begin
      err++;
      $display("FAIL midreset: got valid=%b ready=%b stall=%0d, want 0 1 0", bus.alu_valid, bus.in_ready, stall_cnt);
    end
    bus.alu_ready = 1'b1;
    cyc();
    cyc();
    vec++;
    if (bus.alu_valid !== 1'b0) begin err++; $display("FAIL midreset_after: got valid=%b want 0", bus.alu_valid); end
  endtask
  initial begin
    vec = 0;
    err = 0;
    foreach (rf[i]) rf[i] = 8'h00;
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_opcode = 8'h00;
    bus.in_arg1 = 8'h00;
    bus.in_arg2 = 8'h00;
    bus.in_dest = 8'h00;
    bus.wb_valid = 1'b0;
    bus.wb_addr = 3'd0;
    bus.wb_data = 8'h00;
    bus.alu_ready = 1'b0;
    test_reset();
    test_immediates();
    test_forward();
    test_skid();
    test_snoop();
    test_flush();
    test_back_to_back();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
